// File: rtl/mem_reader36_pkg.sv
// Shared types and constants for the mem_reader36 burst read engine.
package mem_reader36_pkg;

    localparam int WORD_W = 36;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    // Bits needed to hold RD_LAT-1, never less than one.
    function automatic int lat_cnt_w(input int lat);
        if (lat <= 2) return 1;
        return $clog2(lat);
    endfunction

endpackage

// File: rtl/mem_reader36_addr_ctr.sv
// Loadable word-address counter for mem_reader36; wraps modulo 2^ADDR_W.
// MEM_READER_DESC_EN adds a decrement input.
module mem_reader36_addr_ctr #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
`ifdef MEM_READER_DESC_EN
    input  logic              dec,
`endif
    output logic [ADDR_W-1:0] value
);

    // Load wins over stepping so a new burst always starts at its own address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (inc) begin
            value <= value + ADDR_W'(1);
`ifdef MEM_READER_DESC_EN
        end else if (dec) begin
            value <= value - ADDR_W'(1);
`endif
        end
    end

endmodule

// File: rtl/mem_reader36.sv
// Burst read engine: one outstanding read to a fixed-latency 36-bit memory,
// beats returned on a valid/ready stream. MEM_READER_DESC_EN adds req_dir.
module mem_reader36
    import mem_reader36_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 4,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
`ifdef MEM_READER_DESC_EN
    input  logic              req_dir,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int LAT_W = lat_cnt_w(RD_LAT);

    state_t             state;
    logic [LEN_W-1:0]   remain;
    logic [LAT_W-1:0]   lat_cnt;
    logic               accept;
    logic               step;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = (state == IDLE) && req_valid;
    assign step      = (state == RESP) && rsp_ready && !rsp_last;

`ifdef MEM_READER_DESC_EN
    logic dir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir <= 1'b0;
        end else if (accept) begin
            dir <= req_dir;
        end
    end

    mem_reader36_addr_ctr #(.ADDR_W(ADDR_W)) u_addr_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (req_addr),
        .inc      (step && !dir),
        .dec      (step && dir),
        .value    (mem_addr)
    );
`else
    mem_reader36_addr_ctr #(.ADDR_W(ADDR_W)) u_addr_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (req_addr),
        .inc      (step),
        .value    (mem_addr)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remain    <= '0;
            lat_cnt   <= '0;
            mem_en    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        remain <= req_len;
                        mem_en <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en  <= 1'b0;
                    lat_cnt <= LAT_W'(RD_LAT - 1);
                    state   <= WAIT;
                end
                // The memory output is only trusted on the edge the countdown expires.
                WAIT: begin
                    if (lat_cnt == '0) begin
                        rsp_data  <= mem_rdata;
                        rsp_valid <= 1'b1;
                        rsp_last  <= (remain == '0);
                        state     <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        if (rsp_last) begin
                            state <= IDLE;
                        end else begin
                            remain <= remain - 1'b1;
                            mem_en <= 1'b1;
                            state  <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_reader36.sv
// Directed testbench for mem_reader36 with a fixed-latency memory model.
module tb_mem_reader36;

    localparam int ADDR_W = 12;
    localparam int LEN_W  = 4;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              req_dir;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [35:0]       rsp_data;
    logic              rsp_last;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [35:0]       mem_rdata;
    logic              busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [ADDR_W-1:0] iss_q[$];
    logic [35:0]       dq[$];
    logic              lq[$];
    int                cq[$];
    int                stall_en, stall_chg, stall_n, vld_cnt;
    logic              held;
    logic [35:0]       held_d;
    logic [35:0]       pipe[RD_LAT];

    mem_reader36 #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
`ifdef MEM_READER_DESC_EN
        .req_dir   (req_dir),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] memval(input logic [ADDR_W-1:0] a);
        if (a == 12'h010) return 36'h123456789;
        return {a, 12'h5A5, ~a};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        pipe[0] <= mem_en ? memval(mem_addr) : 36'hBADBADBAD;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[RD_LAT-1];

    always @(negedge clk) begin
        if (mem_en) iss_q.push_back(mem_addr);
        if (rsp_valid) vld_cnt++;
        if (rsp_valid && rsp_ready) begin
            dq.push_back(rsp_data);
            lq.push_back(rsp_last);
            cq.push_back(cyc);
        end
        if (rsp_valid && !rsp_ready) begin
            stall_n++;
            if (mem_en) stall_en++;
            if (held && rsp_data != held_d) stall_chg++;
            held   = 1'b1;
            held_d = rsp_data;
        end else begin
            held = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start_req(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l, input logic d);
        iss_q.delete(); dq.delete(); lq.delete(); cq.delete();
        req_addr  = a;
        req_len   = l;
        req_dir   = d;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, busy, 1'b0);
    endtask

    task automatic check_burst(input string tag, input logic [ADDR_W-1:0] a, input int n,
                               input logic down, input bit spacing);
        logic [ADDR_W-1:0] ea;
        chk({tag, "_niss"}, iss_q.size(), n);
        chk({tag, "_nbeat"}, dq.size(), n);
        for (int i = 0; i < n && i < dq.size() && i < iss_q.size(); i++) begin
            ea = down ? a - ADDR_W'(i) : a + ADDR_W'(i);
            chk({tag, "_addr"}, iss_q[i], ea);
            chk({tag, "_data"}, dq[i], memval(ea));
            chk({tag, "_last"}, lq[i], (i == n - 1));
            if (spacing && i > 0) chk({tag, "_gap"}, cq[i] - cq[i-1], RD_LAT + 2);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        req_addr = '0; req_len = '0; req_dir = 1'b0;
        stall_en = 0; stall_chg = 0; stall_n = 0; vld_cnt = 0; held = 1'b0; held_d = '0;
        #12;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_last", rsp_last, 1'b0);
        chk("rst_rsp_data", rsp_data, 36'h0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_addr", mem_addr, 12'h000);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        // Reset pulled in the middle of ISSUE.
        @(negedge clk);
        start_req(12'h055, 4'd0, 1'b0);
        chk("midrst_issue_en", mem_en, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_en", mem_en, 1'b0);
        chk("midrst_req_ready", req_ready, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_mem_addr", mem_addr, 12'h000);
        @(negedge clk) rst_n = 1'b1;
        vld_cnt = 0;
        repeat (8) @(negedge clk);
        chk("midrst_no_stale", vld_cnt, 0);
        chk("midrst_ready_after", req_ready, 1'b1);

        // Single read.
        start_req(12'h010, 4'd0, 1'b0);
        wait_idle("single_idle");
        check_burst("single", 12'h010, 1, 1'b0, 1'b0);
        if (dq.size() > 0) chk("single_const", dq[0], 36'h123456789);

        // Four-beat burst with rsp_ready held high.
        start_req(12'h100, 4'd3, 1'b0);
        wait_idle("b4_idle");
        check_burst("b4", 12'h100, 4, 1'b0, 1'b1);

        // Backpressure on beat 2.
        stall_en = 0; stall_chg = 0; stall_n = 0;
        start_req(12'h040, 4'd2, 1'b0);
        begin
            int n = 0;
            while (dq.size() < 1 && n < 100) begin @(negedge clk); n++; end
            chk("bp_first_beat", dq.size(), 1);
            @(posedge clk);
            #1 rsp_ready = 1'b0;
            n = 0;
            while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
            chk("bp_beat2_valid", rsp_valid, 1'b1);
            repeat (10) @(negedge clk);
            rsp_ready = 1'b1;
        end
        wait_idle("bp_idle");
        chk("bp_no_mem_en", stall_en, 0);
        chk("bp_data_stable", stall_chg, 0);
        chk("bp_stall_seen", stall_n >= 9, 1'b1);
        check_burst("bp", 12'h040, 3, 1'b0, 1'b0);

        // Address wrap at the top of the space.
        start_req(12'hFFE, 4'd3, 1'b0);
        wait_idle("wrap_idle");
        check_burst("wrap", 12'hFFE, 4, 1'b0, 1'b1);

`ifdef MEM_READER_DESC_EN
        start_req(12'h001, 4'd3, 1'b1);
        wait_idle("desc_idle");
        check_burst("desc", 12'h001, 4, 1'b1, 1'b1);
`endif

        // Request offered during a burst is ignored, then taken in IDLE.
        start_req(12'h200, 4'd1, 1'b0);
        req_addr = 12'h300; req_len = 4'd0; req_valid = 1'b1;
        @(negedge clk);
        chk("ign_ready_low", req_ready, 1'b0);
        wait_idle("ign_idle1");
        check_burst("ign", 12'h200, 2, 1'b0, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_idle("ign_idle2");
        chk("ign_niss", iss_q.size(), 3);
        if (iss_q.size() > 2) chk("ign_new_addr", iss_q[2], 12'h300);
        if (dq.size() > 2) chk("ign_new_data", dq[2], memval(12'h300));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=0", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_reader36.md
Name: mem_reader36

Overview:
Read-side companion to the 36-bit register/memory write path. Accepts a burst read request (start address, length), issues one-word reads to a synchronous 36-bit memory with fixed read latency, and returns each word on a valid/ready response stream. The address auto-increments between beats. It sits between the CPU fetch/load logic and the data memory.

Parameters:
ADDR_W, 12, memory word-address width
LEN_W, 4, burst length field width; a burst is req_len+1 words (1..2^LEN_W)
RD_LAT, 2, memory read latency in cycles from mem_en to mem_rdata valid; legal 1..7

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request offered
req_ready  out  1  block can accept a request
req_addr  in  ADDR_W  burst start word address
req_len  in  LEN_W  burst length minus one
rsp_valid  out  1  rsp_data valid
rsp_ready  in  1  consumer accepts beat
rsp_data  out  36  read word
rsp_last  out  1  final beat of burst
mem_en  out  1  one-cycle memory read strobe
mem_addr  out  ADDR_W  memory read address
mem_rdata  in  36  memory read data, valid RD_LAT cycles after mem_en
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1, rsp_valid=0, rsp_last=0, rsp_data=0, mem_en=0, mem_addr=0, busy=0. Reset mid-burst abandons the burst; late mem_rdata is ignored.
- Request handshake: accepted on a rising edge with req_valid&req_ready. The block latches addr and remaining count = req_len. req_ready=1 only in IDLE.
- FSM: IDLE -> ISSUE on accept. ISSUE (1 cycle): mem_en=1, mem_addr=current addr -> WAIT. WAIT: down-counter loaded with RD_LAT-1; when it reaches 0, capture mem_rdata into rsp_data on that edge -> RESP. With RD_LAT=1, WAIT lasts 0 cycles of counting: data is captured on the edge leaving WAIT, so ISSUE->WAIT->RESP.
- RESP: rsp_valid=1; rsp_data held stable until handshake; rsp_last=1 when remaining count==0. On rsp_valid&rsp_ready: if last -> IDLE, else addr+=1, count-=1 -> ISSUE.
- One read is outstanding at a time. Beat spacing is RD_LAT+2 cycles with rsp_ready tied high.
- Address arithmetic: modulo 2^ADDR_W. 0xFFF+1 wraps to 0x000 with no error.
- rsp_ready low stalls in RESP indefinitely. No further mem_en is issued while stalled.
- mem_en is never asserted outside ISSUE.
- req_valid in non-IDLE states is ignored (not accepted, not queued).
- A request accepted in the same cycle as the previous burst's last handshake is impossible by construction: req_ready rises the cycle after IDLE is entered.

Optional Feature:
MEM_READER_DESC_EN
- Defined: adds input port req_dir (1 bit, latched on accept). req_dir=1 makes the address decrement per beat (mod 2^ADDR_W, 0x000-1 -> 0xFFF); req_dir=0 increments.
- Undefined: port absent; the address always increments.

Decomposition:
- Package mem_reader36_pkg: WORD_W=36 constant, state enum (IDLE, ISSUE, WAIT, RESP), and a localparam function for the latency counter width.
- One sub-module, mem_reader36_addr_ctr: loadable ADDR_W counter with inc (and dec under MEM_READER_DESC_EN). Same load/inc/dec semantics as the existing register, clocked, with async active-low reset.

Test Plan:
- Reset: pulse rst_n low mid-ISSUE -> all outputs at reset values immediately; req_ready=1 after release; stale mem_rdata is never presented.
- Single read: req_addr=0x010, req_len=0, RD_LAT=2, memory model returns 36'h123456789 -> exactly one mem_en with mem_addr=0x010; rsp_valid with data 36'h123456789, rsp_last=1; state returns to IDLE.
- Burst 4: req_addr=0x100, req_len=3, rsp_ready=1 -> mem_addr 0x100..0x103 in order; beats spaced 4 cycles; rsp_last only on beat 4.
- Backpressure: rsp_ready low for 10 cycles on beat 2 -> rsp_data stable, no mem_en during the stall; the burst completes correctly after release.
- Wrap: req_addr=0xFFE, req_len=3 -> addresses 0xFFE, 0xFFF, 0x000, 0x001. With MEM_READER_DESC_EN, req_dir=1, req_addr=0x001 -> 0x001, 0x000, 0xFFF, 0xFFE.
- Ignored request: assert req_valid with a new address during a burst -> not accepted, no effect; accepted once back in IDLE.
